// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a 4-word line fill over a req/ack handshake.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module icache_direct #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_read,
  input  logic [WORD_SIZE-1:0]      cpu_addr,
  output logic [WORD_SIZE-1:0]      cpu_data,
  output logic                      cpu_ready,
  input  logic                      flush,
  output logic                      mem_read,
  output logic [WORD_SIZE-1:0]      mem_addr,
  input  logic [4*WORD_SIZE-1:0]    mem_line,
  input  logic                      mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]      hit_count,
  output logic [WORD_SIZE-1:0]      miss_count
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = WORD_SIZE - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_INSTALL = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [NUM_SETS-1:0]  r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_SETS];
  logic [WORD_SIZE-1:0] r_data [NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]     r_fill_tag;
  logic [IDX_W-1:0]     r_fill_idx;
  logic                 r_fill_kill;
  logic                 r_mem_read;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_last_data;

  logic [OFF_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_lookup;
  logic                 w_match;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_install;
  logic [WORD_SIZE-1:0] w_hit_data;

  assign w_off      = cpu_addr[OFF_W-1:0];
  assign w_idx      = cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag      = cpu_addr[WORD_SIZE-1:OFF_W+IDX_W];
  assign w_lookup   = (r_state == S_IDLE) && cpu_read && !flush;
  assign w_match    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit      = w_lookup && w_match;
  assign w_miss     = w_lookup && !w_match;
  assign w_hit_data = r_data[w_idx][w_off];
  // A flush seen at any point of the fill (including the ack cycle) drops the returning line
  assign w_install  = (r_state == S_FILL) && mem_ack && !flush && !r_fill_kill;

  // Hit data is forwarded combinationally; otherwise the last delivered word is held
  assign cpu_ready = w_hit;
  assign cpu_data  = w_hit ? w_hit_data : r_last_data;
  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_miss) w_next_state = S_FILL;
      S_FILL:    if (mem_ack) w_next_state = S_INSTALL;
      S_INSTALL: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Valid bits, fill bookkeeping and memory request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= '0;
      r_fill_tag  <= '0;
      r_fill_idx  <= '0;
      r_fill_kill <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_last_data <= '0;
    end else begin
      if (w_hit) begin
        r_last_data <= w_hit_data;
      end
      if (flush) begin
        r_valid <= '0;
      end else if (w_install) begin
        r_valid[r_fill_idx] <= 1'b1;
      end
      if (r_state == S_FILL) begin
        if (flush) r_fill_kill <= 1'b1;
      end else begin
        r_fill_kill <= 1'b0;
      end
      if (w_miss) begin
        r_fill_tag <= w_tag;
        r_fill_idx <= w_idx;
        r_mem_read <= 1'b1;
        r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
      end else if ((r_state == S_FILL) && mem_ack) begin
        r_mem_read <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[r_fill_idx] <= r_fill_tag;
      for (int k = 0; k < LINE_WORDS; k++) begin
        r_data[r_fill_idx][k] <= mem_line[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] r_hit_count;
  logic [WORD_SIZE-1:0] r_miss_count;

  // Free-running wrap-around statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit)  r_hit_count  <= r_hit_count + WORD_SIZE'(1);
      if (w_miss) r_miss_count <= r_miss_count + WORD_SIZE'(1);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port (read_m1/address1/data1) and instruction memory.
- Hits return the 16-bit instruction in the same cycle.
- Misses stall fetch (cpu_ready=0) while a 4-word line is fetched from memory over a request/acknowledge handshake.
- Also counts hits and misses for CPI analysis.

Parameters:
- WORD_SIZE, 16, width of address and instruction word.
- NUM_SETS, 4, number of lines; power of two, ≥2.
- LINE_WORDS, 4, words per line; fixed at 4 (offset = addr[1:0]).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cpu_read  input  1  fetch request, valid this cycle.
- cpu_addr  input  WORD_SIZE  fetch address (word address).
- cpu_data  output  WORD_SIZE  instruction word; valid when cpu_ready=1.
- cpu_ready  output  1  hit this cycle; datapath treats 0 as fetch stall.
- flush  input  1  invalidate all lines (e.g. self-modifying code / test reset).
- mem_read  output  1  line-fill request to memory.
- mem_addr  output  WORD_SIZE  line-aligned fill address ({tag,index,2'b00}).
- mem_line  input  4*WORD_SIZE  fill data; word k at bits [16k+15:16k].
- mem_ack  input  1  one-cycle pulse; mem_line valid this cycle.
- hit_count  output  WORD_SIZE  hits since reset (only with ICACHE_STATS_EN).
- miss_count  output  WORD_SIZE  misses since reset (only with ICACHE_STATS_EN).

Behaviour:
- Address split: offset = cpu_addr[1:0]; index = cpu_addr[2+log2(NUM_SETS)-1:2]; tag = the remaining upper bits (12 bits at defaults).
- Storage per set: valid bit, tag, 4 data words.
- Async reset (reset_n=0, any state, including mid-fill):
  - state=IDLE; all valid=0; mem_read=0; mem_addr=0; cpu_ready=0; cpu_data=0; counters=0.
  - Data arrays need no reset.
  - A mem_ack arriving after reset release with no outstanding request is ignored.
- Hit: in IDLE, cpu_read=1, valid[index]=1 and tag match.
  - cpu_ready=1 and cpu_data=word[offset] combinationally, zero added latency.
- cpu_read=0 → cpu_ready=0; cpu_data holds its last driven value.
- FSM states IDLE, FILL, INSTALL.
  - IDLE→FILL on a miss (cpu_read=1, not hit, flush=0). fill_tag/fill_index are latched from cpu_addr; mem_read=1 and mem_addr=line address from the next cycle.
  - FILL: mem_read held at 1 and mem_addr stable until mem_ack; cpu_ready=0.
  - On mem_ack: line written, valid=1, tag=fill_tag, mem_read=0 in the same edge; →INSTALL.
  - INSTALL: one bubble cycle, cpu_ready=0; →IDLE. The retried fetch then hits.
  - Minimum miss penalty: miss cycle + FILL cycles + INSTALL cycle. With mem_ack in the first FILL cycle, data returns 3 cycles after the miss cycle.
- cpu_addr change or cpu_read drop during FILL (e.g. branch redirect): the fill is not aborted and the original line is installed. In IDLE the new address is looked up normally; no spurious cpu_ready.
- flush=1:
  - In IDLE/INSTALL: clears all valid bits at the edge; no hit is reported that cycle.
  - In FILL: the outstanding request completes, but on mem_ack the line is discarded (valid stays 0). FSM→INSTALL→IDLE, then re-misses.
  - flush together with mem_ack: flush wins.
- Conflict: two addresses with equal index but different tag evict each other; the newest fill replaces the line unconditionally.
- Index/tag width derived from NUM_SETS; no wrap issues, because line addresses use the full 16-bit space.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: hit_count/miss_count ports exist.
  - hit_count += 1 on each cycle with cpu_ready=1.
  - miss_count += 1 on each IDLE→FILL transition.
  - Both are 16-bit, wrapping at 0xFFFF→0x0000, cleared by reset only.
- Undefined: ports and counter registers are absent; all other behaviour is identical.

Test Plan:
- Reset, cpu_read=1, cpu_addr=0x0005 → cpu_ready=0.
  - Next cycle: mem_read=1, mem_addr=0x0004.
  - mem_ack with line {0x4444,0x3333,0x2222,0x1111} → 2 cycles later cpu_ready=1, cpu_data=0x2222.
- After the above, addresses 0x0004,0x0006,0x0007 back-to-back → cpu_ready=1 each cycle, data 0x1111,0x3333,0x4444, mem_read stays 0.
- Conflict: fill 0x0010, then access 0x0050 (same index 0) → miss, mem_addr=0x0050. Re-access 0x0010 → miss again.
- Redirect: miss on 0x0020 with mem_ack delayed 5 cycles, cpu_addr switched to 0x0008 (cached) after 1 cycle → mem_addr stays 0x0020. After INSTALL, 0x0008 hits and 0x0020 hits.
- Flush during FILL, then ack → line not valid, same address misses again. Flush in IDLE → a previously hit address now misses.
- Reset asserted mid-FILL → mem_read=0 immediately (async). A stray mem_ack is ignored. With ICACHE_STATS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2.
